// File: rtl/nios2_system_nios2_oci_dct_pkg.sv
// Shared types and defaults for the OCI data-trace (DCT) collector.
package nios2_system_nios2_oci_dct_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dct_state_e;

  localparam int DEF_FRAG_W = 2;
  localparam int DEF_FRAGS  = 15;
  localparam int DEF_DEPTH  = 4;

  // Width able to hold a fragment count of 0..frags inclusive.
  function automatic int cnt_width(input int frags);
    return $clog2(frags + 1);
  endfunction

endpackage

// File: rtl/nios2_system_nios2_oci_dct_fifo.sv
// Show-ahead word FIFO for the DCT collector; head entry is visible while not empty.
module nios2_system_nios2_oci_dct_fifo #(
  parameter int  W     = 34,
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [LVL_W-1:0] lvl_q;
  logic             do_push, do_pop;

  assign full    = (lvl_q == LVL_W'(DEPTH));
  assign empty   = (lvl_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage needs no reset: only entries between the pointers are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   lvl_q <= lvl_q + 1'b1;
        2'b01:   lvl_q <= lvl_q - 1'b1;
        default: lvl_q <= lvl_q;
      endcase
    end
  end

  assign head_data = mem_q[rd_q];
  assign level     = lvl_q;

endmodule

// File: rtl/nios2_system_nios2_oci_dct_collector.sv
// Packs trace fragments LSB-first into DCT words, queues them and flushes/drains on test end.
// Build option OCI_DCT_DROP_EN: drop word-completing fragments when the FIFO is full (adds drop_count).
module nios2_system_nios2_oci_dct_collector
  import nios2_system_nios2_oci_dct_pkg::*;
#(
  parameter int  FRAG_W = DEF_FRAG_W,
  parameter int  FRAGS  = DEF_FRAGS,
  parameter int  DEPTH  = DEF_DEPTH,
  localparam int BUF_W  = FRAG_W * FRAGS,
  localparam int CNT_W  = cnt_width(FRAGS),
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frag_valid,
  input  logic [FRAG_W-1:0] frag_data,
  output logic              frag_ready,
  input  logic              test_ending,
  output logic              out_valid,
  output logic [BUF_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_count,
  input  logic              out_ready,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic [LVL_W-1:0]  fifo_level,
`ifdef OCI_DCT_DROP_EN
  output logic [15:0]       drop_count,
`endif
  output logic              test_has_ended
);

  dct_state_e       state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d, packed_w, push_word;
  logic [CNT_W-1:0] cnt_q, cnt_d, push_cnt;
  logic             push, pop, fifo_full, fifo_empty;
  logic             last_frag, accept;

  assign last_frag = (cnt_q == CNT_W'(FRAGS - 1));

`ifdef OCI_DCT_DROP_EN
  assign frag_ready = (state_q == ST_RUN);
`else
  assign frag_ready = (state_q == ST_RUN) && !(last_frag && fifo_full);
`endif

  assign accept = frag_valid && frag_ready;
  assign pop    = out_valid && out_ready;

  // Current buffer with the incoming fragment dropped into slot cnt_q.
  always_comb begin
    packed_w = buf_q;
    for (int k = 0; k < FRAGS; k++) begin
      if (cnt_q == CNT_W'(k)) packed_w[k*FRAG_W +: FRAG_W] = frag_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_word = buf_q;
    push_cnt  = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (!last_frag) begin
            buf_d = packed_w;
            cnt_d = cnt_q + 1'b1;
          end else if (!fifo_full) begin
            push      = 1'b1;
            push_word = packed_w;
            push_cnt  = CNT_W'(FRAGS);
            buf_d     = '0;
            cnt_d     = '0;
          end
        end
        if (test_ending) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = ST_DRAIN;
        end else if (!fifo_full) begin
          push    = 1'b1;
          buf_d   = '0;
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) state_d = ST_DONE;
      end
      default: state_d = ST_DONE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef OCI_DCT_DROP_EN
  logic        drop;
  logic [15:0] drop_q;

  assign drop = accept && last_frag && fifo_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_q <= '0;
    end else if (drop && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_count = drop_q;
`endif

  nios2_system_nios2_oci_dct_fifo #(
    .W     (BUF_W + CNT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ({push_cnt, push_word}),
    .pop       (pop),
    .head_data ({out_count, out_data}),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign out_valid      = !fifo_empty;
  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign test_has_ended = (state_q == ST_DONE);

endmodule

// File: doc/nios2_system_nios2_oci_dct_collector.md
Name: nios2_system_nios2_oci_dct_collector

Overview:
Parametrised successor to the OCI data-trace (DCT) test-bench monitor. It packs narrow trace fragments into DCT words of FRAG_W*FRAGS bits. Completed words are queued in a small FIFO and handed downstream with a valid/ready handshake. On test_ending it flushes any partial word, drains the FIFO, then raises test_has_ended. It sits between the OCI trace source and the trace sink or bench checker.

Parameters:
FRAG_W, 2, bits per trace fragment
FRAGS, 15, fragments per DCT word (word width BUF_W = FRAG_W*FRAGS = 30; this is a localparam)
DEPTH, 4, FIFO depth in words; must be a power of 2 and at least 2
CNT_W is a localparam equal to $clog2(FRAGS+1), which is 4 at the defaults.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
frag_valid  in  1  fragment offered
frag_data  in  FRAG_W  fragment payload
frag_ready  out  1  fragment accepted when frag_valid && frag_ready
test_ending  in  1  single-cycle flush request
out_valid  out  1  FIFO head valid
out_data  out  BUF_W  packed DCT word
out_count  out  CNT_W  valid fragments in out_data (FRAGS, or fewer on a flush)
out_ready  in  1  downstream accepts the head
dct_buffer  out  BUF_W  partial packing register
dct_count  out  CNT_W  fragments currently held in dct_buffer
fifo_level  out  $clog2(DEPTH)+1  words queued
test_has_ended  out  1  sticky; flush and drain complete

Behaviour:
- Reset (asynchronous, reset_n=0) forces these values: state RUN; dct_buffer=0; dct_count=0; FIFO empty; out_valid=0; fifo_level=0; test_has_ended=0; drop_count=0 when the optional feature is built.
- States and transitions:
  - RUN -> FLUSH when test_ending=1.
  - FLUSH -> DRAIN once the partial word is pushed, or immediately if dct_count=0.
  - DRAIN -> DONE when the FIFO is empty.
  - DONE holds until reset.
  - test_ending in any state other than RUN is ignored.
- Packing:
  - An accepted fragment k (0-based) goes to bits [k*FRAG_W +: FRAG_W], so it is LSB-first.
  - Bits above dct_count*FRAG_W stay 0.
- Word completion:
  - Accepting the FRAGS-th fragment pushes {frag, dct_buffer} with out_count=FRAGS into the FIFO on that edge.
  - dct_buffer and dct_count clear to 0 on the same edge.
- frag_ready = (state==RUN) && !(dct_count==FRAGS-1 && fifo_full).
  - fifo_full is registered; a pop in the same cycle does not relieve it (no bypass).
- FIFO:
  - Registered, show-ahead.
  - out_valid rises the cycle after the first push into an empty FIFO.
  - A pop occurs when out_valid && out_ready.
  - A simultaneous push and pop leaves fifo_level unchanged.
  - Read and write pointers wrap modulo DEPTH.
- test_ending in the same cycle as a fragment accept: the fragment is accepted first (ready is evaluated in RUN), and the flush then includes it.
- FLUSH:
  - frag_ready=0.
  - If dct_count>0, push dct_buffer with out_count=dct_count on the first cycle the FIFO is not full, then clear the buffer.
- DONE: test_has_ended=1; frag_ready=0; fragments are ignored.
- Reset asserted mid-flush or mid-drain discards all contents. No words are emitted after reset.

Optional Feature:
OCI_DCT_DROP_EN:
- Defined:
  - frag_ready=1 throughout RUN.
  - A fragment that would complete a word while the FIFO is full is dropped. dct_buffer and dct_count are unchanged.
  - Each drop increments output drop_count [15:0], which saturates at 16'hFFFF.
- Undefined: backpressure only (rule above); the drop_count port is absent.

Decomposition:
- Package nios2_system_nios2_oci_dct_pkg holds:
  - the state enum (RUN, FLUSH, DRAIN, DONE);
  - default FRAG_W/FRAGS/DEPTH constants;
  - a function computing CNT_W.
- One sub-module, nios2_system_nios2_oci_dct_fifo:
  - DEPTH entries of BUF_W+CNT_W bits;
  - show-ahead, with full, empty and level outputs.

Test Plan:
1. 15 fragments 2'b01..2'b11 cycling, out_ready=1 -> one word, out_count=15, out_data bits[1:0] equal the first fragment, out_valid exactly 1 cycle after the 15th accept.
2. out_ready=0, 60 fragments -> 4 words queued, fifo_level=4; dct_count reaches 14 and frag_ready drops to 0; out_ready=1 -> words pop in order and frag_ready returns.
3. 5 fragments, then test_ending -> partial word with out_count=5 and bits[29:10]=0; test_has_ended=1 the cycle after the FIFO empties.
4. test_ending in the same cycle as the 15th fragment accept -> full word pushed; no partial word; DONE after drain; later frag_valid is ignored.
5. reset_n pulsed low mid-DRAIN with 3 words queued -> out_valid=0 and fifo_level=0 immediately; test_has_ended=0.
6. OCI_DCT_DROP_EN defined, FIFO full, 20 extra fragments offered -> frag_ready stays 1 and drop_count increments by 1 for each fragment dropped while the FIFO stays full.
